uart: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 rtl/uart_tx.sv | 116 +++++++++++
 rtl/uart.sv | 61 ++++++
 tb/tb_uart.sv | 277 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared types and default timing for the uart transmitter/receiver pair.
package uart_pkg;

  // Frame position shared by both engines.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_STOP_WIDTH    = 1;
  localparam int DEF_PARITY_WIDTH  = 1;
  localparam int DEF_CLKS_PER_TICK = 16;
  localparam int DEF_TICKS_PER_BIT = 16;

  // Level of an idle serial line (also the stop-bit level).
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator shared by the TX and RX engines.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] count;

  // Count 0..CLKS_PER_TICK-1 and wrap.
  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) count <= '0;
    else if (count == LAST) count <= '0;
    else count <= count + CW'(1);
  end

  assign o_tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// Receive engine: synchronize, find start edge, sample each bit at its midpoint.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int STOP_WIDTH    = DEF_STOP_WIDTH,
  parameter int PARITY_WIDTH  = DEF_PARITY_WIDTH,
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_tick,
  input  logic                    i_rx_data,
  output logic                    o_rx_done,
  output logic [DATA_WIDTH-1:0]   o_rx_data,
  output logic [PARITY_WIDTH-1:0] o_parity
);

  localparam int FW = DATA_WIDTH + PARITY_WIDTH;
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = $clog2(FW + STOP_WIDTH + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] PAR_LAST  = BW'(PARITY_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_WIDTH - 1);

  logic [1:0]              sync_q;
  logic                    rx_s;
  frame_state_e            state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [FW-1:0]           shreg_q, shreg_d;
  logic                    ok_q, ok_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [PARITY_WIDTH-1:0] par_q, par_d;
  logic                    bit_end;

  assign rx_s    = sync_q[1];
  assign bit_end = i_tick && (tick_q == TICK_LAST);

  // Two-flop synchronizer for the asynchronous line, plus the engine registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_q  <= {2{LINE_IDLE}};
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      par_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], i_rx_data};
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end

  // Frame tracking: realign to mid-start, then sample once per bit time.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    data_d  = data_q;
    par_d   = par_q;
    if (state_q != IDLE && i_tick) tick_d = bit_end ? '0 : tick_q + TW'(1);
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (i_tick && tick_q == TICK_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          ok_d    = 1'b1;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA, PARITY: begin
        if (bit_end) begin
          shreg_d = {rx_s, shreg_q[FW-1:1]};
          bit_d   = bit_q + BW'(1);
          if (state_q == DATA && bit_q == DATA_LAST) begin
            state_d = PARITY;
            bit_d   = '0;
          end else if (state_q == PARITY && bit_q == PAR_LAST) begin
            state_d = STOP;
            bit_d   = '0;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          ok_d  = ok_q && rx_s;
          bit_d = bit_q + BW'(1);
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            if (ok_q && rx_s) begin
              data_d = shreg_q[DATA_WIDTH-1:0];
              par_d  = shreg_q[FW-1:DATA_WIDTH];
              done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rx_done = done_q;
  assign o_rx_data = data_q;
  assign o_parity  = par_q;

endmodule

// File: rtl/uart_tx.sv
// Transmit engine: start bit, data LSB first, parity field LSB first, stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int STOP_WIDTH    = DEF_STOP_WIDTH,
  parameter int PARITY_WIDTH  = DEF_PARITY_WIDTH,
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_tick,
  input  logic                    i_tx_signal,
  input  logic [DATA_WIDTH-1:0]   i_tx_result,
  input  logic [PARITY_WIDTH-1:0] i_parity,
  output logic                    o_tx_data,
  output logic                    o_tx_done,
  output logic                    o_tx_available
);

  localparam int FW = DATA_WIDTH + PARITY_WIDTH;
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = $clog2(FW + STOP_WIDTH + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] PAR_LAST  = BW'(PARITY_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_WIDTH - 1);

  frame_state_e  state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic          line_q, line_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = i_tick && (tick_q == TICK_LAST);

  // State register; the line and done pulse are registered to stay glitch-free.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      line_q  <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-line logic; the frame payload shifts out of shreg_q[0].
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    line_d  = line_q;
    done_d  = 1'b0;
    if (state_q != IDLE && i_tick) tick_d = bit_end ? '0 : tick_q + TW'(1);
    case (state_q)
      IDLE: begin
        if (i_tx_signal) begin
          state_d = START;
          shreg_d = {i_parity, i_tx_result};
          line_d  = 1'b0;
          tick_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          line_d  = shreg_q[0];
        end
      end
      DATA, PARITY: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          line_d  = shreg_q[1];
          bit_d   = bit_q + BW'(1);
          if (state_q == DATA && bit_q == DATA_LAST) begin
            state_d = PARITY;
            bit_d   = '0;
          end else if (state_q == PARITY && bit_q == PAR_LAST) begin
            state_d = STOP;
            bit_d   = '0;
            line_d  = LINE_IDLE;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_d = bit_q + BW'(1);
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_tx_data      = line_q;
  assign o_tx_done      = done_q;
  assign o_tx_available = (state_q == IDLE);

endmodule

// File: rtl/uart.sv
// Full-duplex uart: one shared tick generator feeding independent TX and RX engines.
module uart
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int STOP_WIDTH    = DEF_STOP_WIDTH,
  parameter int PARITY_WIDTH  = DEF_PARITY_WIDTH,
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK,
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_rx_data,
  input  logic                    i_tx_signal,
  input  logic [DATA_WIDTH-1:0]   i_tx_result,
  input  logic [PARITY_WIDTH-1:0] i_parity,
  output logic                    o_rx_done,
  output logic [DATA_WIDTH-1:0]   o_rx_data,
  output logic [PARITY_WIDTH-1:0] o_parity,
  output logic                    o_tx_data,
  output logic                    o_tx_done,
  output logic                    o_tx_available
);

  logic tick;

  uart_baud_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_baud_gen (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  uart_tx #(
    .DATA_WIDTH(DATA_WIDTH), .STOP_WIDTH(STOP_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH), .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_tx (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_tick         (tick),
    .i_tx_signal    (i_tx_signal),
    .i_tx_result    (i_tx_result),
    .i_parity       (i_parity),
    .o_tx_data      (o_tx_data),
    .o_tx_done      (o_tx_done),
    .o_tx_available (o_tx_available)
  );

  uart_rx #(
    .DATA_WIDTH(DATA_WIDTH), .STOP_WIDTH(STOP_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH), .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_rx (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_tick    (tick),
    .i_rx_data (i_rx_data),
    .o_rx_done (o_rx_done),
    .o_rx_data (o_rx_data),
    .o_parity  (o_parity)
  );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: loopback and directly driven RX frames.
module tb_uart;

  localparam int BIT_CLKS = 256;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_line;
  logic       loop_en;
  logic       rx_in;
  logic       tx_signal;
  logic [7:0] tx_result;
  logic [0:0] tx_parity;
  logic       o_rx_done;
  logic [7:0] o_rx_data;
  logic [0:0] o_parity;
  logic       o_tx_data;
  logic       o_tx_done;
  logic       o_tx_available;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  logic [8:0] rx_q[$];

  assign rx_in = loop_en ? o_tx_data : rx_line;

  always #5 clock = ~clock;

  uart dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_rx_data      (rx_in),
    .i_tx_signal    (tx_signal),
    .i_tx_result    (tx_result),
    .i_parity       (tx_parity),
    .o_rx_done      (o_rx_done),
    .o_rx_data      (o_rx_data),
    .o_parity       (o_parity),
    .o_tx_data      (o_tx_data),
    .o_tx_done      (o_tx_done),
    .o_tx_available (o_tx_available)
  );

  // Scoreboard of every completed frame, {parity, data}.
  always @(posedge clock) begin
    if (o_rx_done === 1'b1) begin
      rx_cnt++;
      rx_q.push_back({o_parity, o_rx_data});
    end
    if (o_tx_done === 1'b1) tx_cnt++;
  end

  // Line level during each of the 11 bit slots: start, 8 data LSB first, parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  function automatic logic [8:0] pop_rx();
    if (rx_q.size() == 0) return 9'bx;
    return rx_q.pop_front();
  endfunction

  task automatic drive_rx_frame(input logic [7:0] d, input logic p, input logic stop_lvl,
                                input int stop_len);
    logic [10:0] bits;
    bits = frame_bits(d, p);
    for (int k = 0; k < 10; k++) begin
      rx_line = bits[k];
      repeat (BIT_CLKS) @(negedge clock);
    end
    rx_line = stop_lvl;
    repeat (stop_len) @(negedge clock);
    rx_line = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic p, output logic ok);
    int n;
    ok = 1'b1;
    tx_result = d;
    tx_parity = p;
    tx_signal = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (o_tx_available && n < 50);
    tx_signal = 1'b0;
    if (o_tx_available !== 1'b0) ok = 1'b0;
    n = 0;
    while (o_tx_done !== 1'b1 && n < 4000) begin @(negedge clock); n++; end
    if (o_tx_done !== 1'b1) ok = 1'b0;
  endtask

  task automatic wait_rx(input int target, output logic ok);
    int n;
    n = 0;
    while (rx_cnt < target && n < 4000) begin @(negedge clock); n++; end
    ok = (rx_cnt >= target);
  endtask

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b1; loop_en = 1'b1; rx_line = 1'b1; tx_signal = 1'b0;
    tx_result = '0; tx_parity = '0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    got = {o_tx_data, o_tx_available, o_tx_done, o_rx_done, o_rx_data, o_parity};
    checks++;
    if (got !== 13'b1_1_0_0_00000000_0) begin
      errors++; $display("FAIL reset_values got=%b exp=%b", got, 13'b1_1_0_0_00000000_0);
    end
  endtask

  task automatic test_loopback(input logic [7:0] d, input logic p);
    int rx0, tx0; logic ok; logic [8:0] got;
    loop_en = 1'b1;
    rx0 = rx_cnt; tx0 = tx_cnt;
    send_byte(d, p, ok);
    repeat (20) @(negedge clock);
    checks++; if (!ok) begin errors++; $display("FAIL loop_tx_timeout got=0 exp=1"); end
    checks++; if (tx_cnt - tx0 != 1) begin errors++; $display("FAIL loop_tx_done_count got=%0d exp=1", tx_cnt - tx0); end
    checks++; if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL loop_rx_done_count got=%0d exp=1", rx_cnt - rx0); end
    got = pop_rx();
    checks++; if (got !== {p, d}) begin errors++; $display("FAIL loop_rx_frame got=%h exp=%h", got, {p, d}); end
    checks++; if ({o_parity, o_rx_data} !== {p, d}) begin
      errors++; $display("FAIL loop_rx_outputs got=%h exp=%h", {o_parity, o_rx_data}, {p, d});
    end
    checks++; if (o_tx_available !== 1'b1) begin errors++; $display("FAIL loop_available got=%b exp=1", o_tx_available); end
  endtask

  task automatic test_waveform();
    int n; logic [10:0] exp; logic [8:0] got;
    loop_en = 1'b1;
    exp = frame_bits(8'h01, 1'b0);
    tx_result = 8'h01; tx_parity = 1'b0; tx_signal = 1'b1;
    @(negedge clock);
    tx_signal = 1'b0;
    checks++; if (o_tx_data !== 1'b0) begin errors++; $display("FAIL wave_start_latency got=%b exp=0", o_tx_data); end
    n = 0;
    while (o_tx_data === 1'b0 && n < 300) begin @(negedge clock); n++; end
    checks++; if (n < 241 || n > 256) begin errors++; $display("FAIL wave_start_len got=%0d exp=241..256", n); end
    n = 0;
    while (o_tx_data === 1'b1 && n < 300) begin @(negedge clock); n++; end
    checks++; if (n < 255 || n > 257) begin errors++; $display("FAIL wave_bit1_len got=%0d exp=256", n); end
    for (int b = 2; b <= 10; b++) begin
      repeat (BIT_CLKS / 2) @(negedge clock);
      checks++;
      if (o_tx_data !== exp[b]) begin
        errors++; $display("FAIL wave_level bit=%0d got=%b exp=%b", b, o_tx_data, exp[b]);
      end
      repeat (BIT_CLKS / 2) @(negedge clock);
    end
    repeat (20) @(negedge clock);
    got = pop_rx();
    checks++; if (got !== 9'h001) begin errors++; $display("FAIL wave_rx_frame got=%h exp=001", got); end
  endtask

  task automatic test_midframe_request();
    int rx0, tx0, n; logic [8:0] got;
    loop_en = 1'b1;
    rx0 = rx_cnt; tx0 = tx_cnt;
    tx_result = 8'h3C; tx_parity = 1'b0; tx_signal = 1'b1;
    @(negedge clock);
    tx_signal = 1'b0;
    repeat (1000) @(negedge clock);
    tx_result = 8'hFF; tx_parity = 1'b1; tx_signal = 1'b1;
    repeat (200) @(negedge clock);
    tx_signal = 1'b0;
    n = 0;
    while (o_tx_done !== 1'b1 && n < 3000) begin @(negedge clock); n++; end
    repeat (2000) @(negedge clock);
    checks++; if (tx_cnt - tx0 != 1) begin errors++; $display("FAIL busy_tx_count got=%0d exp=1", tx_cnt - tx0); end
    checks++; if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL busy_rx_count got=%0d exp=1", rx_cnt - rx0); end
    got = pop_rx();
    checks++; if (got !== 9'h03C) begin errors++; $display("FAIL busy_rx_frame got=%h exp=03c", got); end
  endtask

  task automatic test_rx_random();
    logic [7:0] d; logic p; logic ok; logic [8:0] got;
    loop_en = 1'b0; rx_line = 1'b1;
    repeat (50) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom); p = 1'($urandom_range(0, 1));
      drive_rx_frame(d, p, 1'b1, BIT_CLKS);
      wait_rx(rx_cnt, ok);
      got = pop_rx();
      checks++; if (got !== {p, d}) begin errors++; $display("FAIL rx_rand[%0d] got=%h exp=%h", i, got, {p, d}); end
    end
  endtask

  task automatic test_rx_errors();
    int rx0; logic [7:0] d; logic p; logic [8:0] got;
    loop_en = 1'b0; rx_line = 1'b1;
    rx0 = rx_cnt;
    rx_line = 1'b0;
    repeat (5 * 16) @(negedge clock);
    rx_line = 1'b1;
    repeat (600) @(negedge clock);
    checks++; if (rx_cnt != rx0) begin errors++; $display("FAIL glitch_no_done got=%0d exp=0", rx_cnt - rx0); end
    d = 8'($urandom); p = 1'($urandom_range(0, 1));
    drive_rx_frame(d, p, 1'b1, BIT_CLKS);
    repeat (20) @(negedge clock);
    got = pop_rx();
    checks++; if (got !== {p, d}) begin errors++; $display("FAIL after_glitch got=%h exp=%h", got, {p, d}); end
    rx0 = rx_cnt;
    drive_rx_frame(~d, ~p, 1'b0, 200);
    repeat (800) @(negedge clock);
    checks++; if (rx_cnt != rx0) begin errors++; $display("FAIL framing_no_done got=%0d exp=0", rx_cnt - rx0); end
    checks++; if ({o_parity, o_rx_data} !== {p, d}) begin
      errors++; $display("FAIL framing_hold got=%h exp=%h", {o_parity, o_rx_data}, {p, d});
    end
  endtask

  task automatic test_reset_midframe();
    int rx0, tx0;
    loop_en = 1'b1;
    rx0 = rx_cnt; tx0 = tx_cnt;
    tx_result = 8'hC3; tx_parity = 1'b1; tx_signal = 1'b1;
    @(negedge clock);
    tx_signal = 1'b0;
    repeat (1200) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({o_tx_data, o_tx_available, o_rx_data} !== {2'b11, 8'h00}) begin
      errors++; $display("FAIL midreset_state got=%b exp=%b", {o_tx_data, o_tx_available, o_rx_data}, {2'b11, 8'h00});
    end
    repeat (3500) @(negedge clock);
    checks++; if (tx_cnt != tx0 || rx_cnt != rx0) begin
      errors++; $display("FAIL midreset_no_done got=%0d/%0d exp=0/0", tx_cnt - tx0, rx_cnt - rx0);
    end
    test_loopback(8'h5A, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4]; logic par [4]; int rx0, tx0, n; logic ok; logic [8:0] got;
    bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++) par[i] = 1'($urandom_range(0, 1));
    loop_en = 1'b1;
    rx0 = rx_cnt; tx0 = tx_cnt;
    tx_result = bytes[0]; tx_parity = par[0]; tx_signal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (o_tx_available && n < 50);
      if (i < 3) begin tx_result = bytes[i + 1]; tx_parity = par[i + 1]; end
      n = 0;
      while (o_tx_done !== 1'b1 && n < 4000) begin @(negedge clock); n++; end
      checks++; if (o_tx_done !== 1'b1) begin errors++; $display("FAIL b2b_timeout frame=%0d got=0 exp=1", i); end
      if (i == 3) tx_signal = 1'b0;
    end
    wait_rx(rx0 + 4, ok);
    repeat (20) @(negedge clock);
    checks++; if (tx_cnt - tx0 != 4) begin errors++; $display("FAIL b2b_tx_count got=%0d exp=4", tx_cnt - tx0); end
    for (int i = 0; i < 4; i++) begin
      got = pop_rx();
      checks++; if (got !== {par[i], bytes[i]}) begin
        errors++; $display("FAIL b2b_rx[%0d] got=%h exp=%h", i, got, {par[i], bytes[i]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback(8'hA5, 1'b1);
    test_waveform();
    test_midframe_request();
    test_rx_random();
    test_rx_errors();
    test_reset_midframe();
    test_back_to_back();
    for (int i = 0; i < 2; i++) test_loopback(8'($urandom), 1'($urandom_range(0, 1)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
